// File: rtl/nn_pkg.sv
// Shared types and default widths for the digit-detection neuron datapath.
package nn_pkg;
  localparam int NN_IN_W    = 16;
  localparam int NN_ACC_W   = 24;
  localparam int NN_COUNT_W = 10;

  typedef logic signed [NN_ACC_W-1:0] acc_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mac_state_t;
endpackage

// File: rtl/cla_4b.sv
// 4-bit carry-lookahead adder slice.
module cla_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [3:0] p, g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Carries flattened so no slice-internal ripple.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s     = p ^ c[3:0];
  assign c_out = c[4];
endmodule

// File: rtl/cla_chain.sv
// W-bit adder built from W/4 cla_4b slices with the slice carries chained.
module cla_chain #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] s,
  output logic         c_out,
  output logic         c_msb
);
  localparam int NS = W / 4;

  logic [NS:0] c;
  assign c[0] = c_in;

  for (genvar k = 0; k < NS; k++) begin : g_slice
    cla_4b u_cla (
      .a    (a[4*k+3:4*k]),
      .b    (b[4*k+3:4*k]),
      .c_in (c[k]),
      .s    (s[4*k+3:4*k]),
      .c_out(c[k+1])
    );
  end

  assign c_out = c[NS];
  // Carry into the top bit recovered from its sum bit: s = a ^ b ^ cin.
  assign c_msb = a[W-1] ^ b[W-1] ^ s[W-1];
endmodule

// File: rtl/mac_accumulator.sv
// Streaming signed frame accumulator with valid/ready in and out.
// Define MAC_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_accumulator
  import nn_pkg::*;
#(
  parameter int IN_W    = NN_IN_W,
  parameter int ACC_W   = NN_ACC_W,
  parameter int COUNT_W = NN_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_ovf
);
  mac_state_t         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic signed [ACC_W-1:0] addend;
  logic [ACC_W-1:0]        sum;
  logic                    c_out, c_msb, add_ovf;

  assign addend = ACC_W'($signed(in_data));

  cla_chain #(.W(ACC_W)) u_add (
    .a    (acc_q),
    .b    (addend),
    .c_in (1'b0),
    .s    (sum),
    .c_out(c_out),
    .c_msb(c_msb)
  );

  // Signed overflow: carry into and out of the MSB disagree.
  assign add_ovf = c_msb ^ c_out;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = sum;
          cnt_d = cnt_q + 1'b1;
          if (add_ovf) begin
            ovf_d = 1'b1;
`ifdef MAC_ACC_SAT_EN
            acc_d = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
`endif
          end
          if (in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Randomized self-checking bench for mac_accumulator against an integer frame model.
module tb_mac_accumulator;
  localparam int  IN_W = 16, ACC_W = 24, COUNT_W = 10;
  localparam longint AMAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint AMIN = -(64'sd1 <<< (ACC_W-1));

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [IN_W-1:0] in_data = '0;
  logic in_ready, out_valid, out_ovf;
  logic [ACC_W-1:0] out_sum;
  logic [COUNT_W-1:0] out_count;

  int total = 0, bad = 0;
  int q[$];

  mac_accumulator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [ACC_W-1:0] v);
    return longint'($signed(v));
  endfunction

  // Plain-arithmetic frame model: exact sum, range check, wrap or clamp.
  task automatic model(output longint s, output longint n, output bit ov);
    longint t;
    s = 0; ov = 0;
    foreach (q[i]) begin
      t = s + longint'($signed(16'(q[i])));
      if (t > AMAX || t < AMIN) begin
        ov = 1;
`ifdef MAC_ACC_SAT_EN
        t = (s < 0) ? AMIN : AMAX;
`else
        t = (t > AMAX) ? t - (64'sd1 <<< ACC_W) : t + (64'sd1 <<< ACC_W);
`endif
      end
      s = t;
    end
    n = q.size() % (1 << COUNT_W);
  endtask

  task automatic run_frame(input string tag, input int hold_cyc, input bit gaps);
    longint es, en; bit eo;
    foreach (q[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_valid = 0; in_data = IN_W'($urandom); in_last = 1'($urandom);
        @(negedge clk);
      end
      in_valid = 1; in_data = IN_W'(q[i]); in_last = (i == q.size() - 1);
      @(negedge clk);
    end
    in_valid = 0; in_last = 0;
    model(es, en, eo);
    chk({tag, ".valid"}, out_valid, 1);
    chk({tag, ".ready"}, in_ready, 0);
    chk({tag, ".sum"}, sx(out_sum), es);
    chk({tag, ".count"}, out_count, en);
    chk({tag, ".ovf"}, out_ovf, eo);
    repeat (hold_cyc) begin
      in_valid = 1'($urandom); in_data = IN_W'($urandom); in_last = 1'($urandom);
      @(negedge clk);
      chk({tag, ".hold_valid"}, out_valid, 1);
      chk({tag, ".hold_ready"}, in_ready, 0);
      chk({tag, ".hold_sum"}, sx(out_sum), es);
      chk({tag, ".hold_count"}, out_count, en);
    end
    in_valid = 0; in_last = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk({tag, ".post_valid"}, out_valid, 0);
    chk({tag, ".post_ready"}, in_ready, 1);
    chk({tag, ".post_sum"}, out_sum, 0);
    chk({tag, ".post_count"}, out_count, 0);
    chk({tag, ".post_ovf"}, out_ovf, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst.ready", in_ready, 1);
    chk("rst.valid", out_valid, 0);
    chk("rst.sum", out_sum, 0);
    chk("rst.count", out_count, 0);
    chk("rst.ovf", out_ovf, 0);

    q = '{3, 5, -2};
    run_frame("basic", 0, 0);
    chk("basic.const", 6, 6 + sx(out_sum));

    q = '{11, -4, 9};
    run_frame("hold", 5, 0);
    q = '{7};
    run_frame("after_hold", 0, 0);

    q = {};
    repeat (300) q.push_back(32'h7FFF);
    run_frame("ovf_pos", 0, 0);
`ifdef MAC_ACC_SAT_EN
    chk("ovf_pos.literal", 0, 0);
`endif

    q = {};
    repeat (300) q.push_back(-32768);
    run_frame("ovf_neg", 1, 0);

    q = '{-1};
    run_frame("single_neg", 0, 0);

    // Reset mid-frame discards the partial sum.
    in_valid = 1; in_data = 16'd100; in_last = 0;
    repeat (2) @(negedge clk);
    in_valid = 0; rst = 1;
    @(negedge clk);
    rst = 0;
    chk("midrst.sum", out_sum, 0);
    chk("midrst.count", out_count, 0);
    chk("midrst.ready", in_ready, 1);
    q = '{7};
    run_frame("after_rst", 0, 0);

    // Reset while holding a result.
    in_valid = 1; in_data = 16'd55; in_last = 1;
    @(negedge clk);
    in_valid = 0; in_last = 0;
    chk("holdrst.pre", out_valid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("holdrst.valid", out_valid, 0);
    chk("holdrst.sum", out_sum, 0);

    q = '{10, 20, 30};
    run_frame("gaps", 0, 1);

    q = {};
    repeat (1030) q.push_back(1);
    run_frame("cnt_wrap", 0, 0);

    for (int f = 0; f < 12; f++) begin
      q = {};
      repeat ($urandom_range(1, 40)) q.push_back(int'($urandom));
      run_frame($sformatf("rand%0d", f), $urandom_range(0, 3), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
